// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 values, memory sizes,
// fault causes, FSM states, and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } fault_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_illegal(input logic store, input logic [2:0] f3);
    if (store) begin
      return f3 > F3_W;
    end
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  // funct3[1:0] is the access size for every legal load and store encoding.
  function automatic logic op_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_mask(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      SIZE_BYTE: return {24'h000000, data[7:0]};
      SIZE_HALF: return {16'h0000, data[15:0]};
      default:   return data;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load result extension: selects sign or zero extension of the
// right-justified memory datum according to the load funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   ext = {24'h000000, raw[7:0]};
      F3_HU:   ext = {16'h0000, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: validates one memory op at a time, runs the memory_cont
// request handshake with a timeout, and returns extended load data or a fault.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic [31:0] mem_address,
  output logic        mem_rw_req,
  output logic        mem_rw,
  output logic [31:0] mem_write_data,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_read_data,
  input  logic        mem_data_valid
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e       state_reg, state_next;
  logic [15:0]  count_reg, count_next;
  logic [2:0]   f3_reg, f3_next;
  logic [4:0]   rd_reg, rd_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;
  logic         wb_we_reg, wb_we_next;
  logic [4:0]   wb_rd_reg, wb_rd_next;
  logic [31:0]  wb_data_reg, wb_data_next;
  logic         fault_reg, fault_next;
  fault_cause_e cause_reg, cause_next;
  logic [31:0]  fault_addr_reg, fault_addr_next;
  logic [31:0]  addr_reg, addr_next;
  logic         req_reg, req_next;
  logic         rw_reg, rw_next;
  logic [31:0]  wdata_reg, wdata_next;
  logic [1:0]   size_reg, size_next;
  logic [31:0]  ext_data;

  load_extend u_load_extend (
    .funct3 (f3_reg),
    .raw    (mem_read_data),
    .ext    (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      f3_reg         <= '0;
      rd_reg         <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      wb_we_reg      <= 1'b0;
      wb_rd_reg      <= '0;
      wb_data_reg    <= '0;
      fault_reg      <= 1'b0;
      cause_reg      <= CAUSE_NONE;
      fault_addr_reg <= '0;
      addr_reg       <= '0;
      req_reg        <= 1'b0;
      rw_reg         <= 1'b0;
      wdata_reg      <= '0;
      size_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      f3_reg         <= f3_next;
      rd_reg         <= rd_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      wb_we_reg      <= wb_we_next;
      wb_rd_reg      <= wb_rd_next;
      wb_data_reg    <= wb_data_next;
      fault_reg      <= fault_next;
      cause_reg      <= cause_next;
      fault_addr_reg <= fault_addr_next;
      addr_reg       <= addr_next;
      req_reg        <= req_next;
      rw_reg         <= rw_next;
      wdata_reg      <= wdata_next;
      size_reg       <= size_next;
    end
  end

  // Status outputs are computed for the state being entered so they are
  // registered yet still line up with that state.
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    f3_next         = f3_reg;
    rd_next         = rd_reg;
    done_next       = 1'b0;
    wb_we_next      = 1'b0;
    wb_rd_next      = wb_rd_reg;
    wb_data_next    = wb_data_reg;
    fault_next      = 1'b0;
    cause_next      = cause_reg;
    fault_addr_next = fault_addr_reg;
    addr_next       = addr_reg;
    req_next        = req_reg;
    rw_next         = rw_reg;
    wdata_next      = wdata_reg;
    size_next       = size_reg;

    case (state_reg)
      ST_IDLE: begin
        if (ex_valid) begin
          f3_next = ex_funct3;
          rd_next = ex_rd;
          if (op_illegal(ex_store, ex_funct3)) begin
            state_next      = ST_DONE;
            done_next       = 1'b1;
            fault_next      = 1'b1;
            cause_next      = CAUSE_ILLEGAL;
            fault_addr_next = ex_addr;
          end else if (op_misaligned(ex_funct3, ex_addr[1:0])) begin
            state_next      = ST_DONE;
            done_next       = 1'b1;
            fault_next      = 1'b1;
            cause_next      = CAUSE_MISALIGN;
            fault_addr_next = ex_addr;
          end else begin
            state_next = ST_WAIT;
            count_next = '0;
            req_next   = 1'b1;
            rw_next    = ex_store;
            addr_next  = ex_addr;
            size_next  = ex_funct3[1:0];
            wdata_next = ex_store ? store_mask(ex_funct3, ex_wdata) : 32'h0;
          end
        end
      end
      ST_WAIT: begin
        // A valid on the last count cycle takes precedence over the timeout.
        if (mem_data_valid) begin
          state_next = ST_DONE;
          req_next   = 1'b0;
          done_next  = 1'b1;
          cause_next = CAUSE_NONE;
          if (!rw_reg) begin
            wb_we_next   = 1'b1;
            wb_rd_next   = rd_reg;
            wb_data_next = ext_data;
          end
        end else if (count_reg == TIMEOUT_LAST) begin
          state_next      = ST_DONE;
          req_next        = 1'b0;
          done_next       = 1'b1;
          fault_next      = 1'b1;
          cause_next      = CAUSE_TIMEOUT;
          fault_addr_next = addr_reg;
        end else begin
          count_next = count_reg + 16'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  assign lsu_busy       = busy_reg;
  assign lsu_done       = done_reg;
  assign wb_we          = wb_we_reg;
  assign wb_rd          = wb_rd_reg;
  assign wb_data        = wb_data_reg;
  assign fault          = fault_reg;
  assign fault_cause    = cause_reg;
  assign fault_addr     = fault_addr_reg;
  assign mem_address    = addr_reg;
  assign mem_rw_req     = req_reg;
  assign mem_rw         = rw_reg;
  assign mem_write_data = wdata_reg;
  assign mem_size       = size_reg;

endmodule
